// File: rtl/line_pkg.sv
// ---------------------------------------------------------------------------
// line_pkg
// Shared definitions for the on-screen line position tracker:
//   - motion mode encodings (value 3 is decoded as clamp by the tracker)
//   - bounce FSM state enum
//   - default vertical bounds of the visible line area
// ---------------------------------------------------------------------------
package line_pkg;

  localparam logic [1:0] MODE_CLAMP  = 2'd0;
  localparam logic [1:0] MODE_WRAP   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_RUN_UP = 2'd1,
    ST_RUN_DW = 2'd2
  } state_e;

  localparam int DEF_MIN_POS = 18;
  localparam int DEF_MAX_POS = 487;

endpackage

// File: rtl/line_pos_step.sv
// ---------------------------------------------------------------------------
// line_pos_step
// Purely combinational single-step position calculator.
// Ports:
//   pos        in  WIDTH  current position (always within [MIN_POS, MAX_POS])
//   up         in  1      request a step toward MAX_POS
//   dw         in  1      request a step toward MIN_POS (ignored when up=1)
//   wrap_en    in  1      1: wrap around the range, 0: saturate at the bounds
//   next_pos   out WIDTH  position after the step (pos when no request)
//   limit_flag out 1      wrap mode: a wrap occurred;
//                         saturate mode: result sits on the limit of travel
// All sums are formed one bit wider than the position so nothing overflows.
// ---------------------------------------------------------------------------
module line_pos_step
  import line_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int MIN_POS = DEF_MIN_POS,
  parameter int MAX_POS = DEF_MAX_POS,
  parameter int STEP    = 1
) (
  input  logic [WIDTH-1:0] pos,
  input  logic             up,
  input  logic             dw,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] next_pos,
  output logic             limit_flag
);

  localparam logic [WIDTH:0] MIN_X   = (WIDTH+1)'(MIN_POS);
  localparam logic [WIDTH:0] MAX_X   = (WIDTH+1)'(MAX_POS);
  localparam logic [WIDTH:0] STEP_X  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] RANGE_X = (WIDTH+1)'(MAX_POS - MIN_POS + 1);

  logic [WIDTH:0] pos_x;
  logic [WIDTH:0] sum_x;
  logic [WIDTH:0] dif_x;

  assign pos_x = {1'b0, pos};
  assign sum_x = pos_x + STEP_X;
  assign dif_x = pos_x - STEP_X;

  always_comb begin
    next_pos   = pos;
    limit_flag = 1'b0;
    if (up) begin
      if (sum_x > MAX_X) begin
        limit_flag = 1'b1;
        next_pos   = wrap_en ? WIDTH'(sum_x - RANGE_X) : WIDTH'(MAX_X);
      end else begin
        next_pos   = WIDTH'(sum_x);
        limit_flag = !wrap_en && (sum_x == MAX_X);
      end
    end else if (dw) begin
      // pos - STEP < MIN_POS, tested without forming a negative value
      if (pos_x < MIN_X + STEP_X) begin
        limit_flag = 1'b1;
        next_pos   = wrap_en ? WIDTH'(pos_x + RANGE_X - STEP_X) : WIDTH'(MIN_X);
      end else begin
        next_pos   = WIDTH'(dif_x);
        limit_flag = !wrap_en && (dif_x == MIN_X);
      end
    end
  end

endmodule

// File: rtl/line_pos_tracker.sv
// ---------------------------------------------------------------------------
// line_pos_tracker
// Position register for one on-screen line with clamp, wrap and bounce modes.
// Ports:
//   clk        in  1      system clock
//   reset      in  1      synchronous active-high reset
//   frame_tick in  1      one-cycle strobe per frame; moves happen only here
//   UP / DW    in  1      move (manual modes) or start (bounce) up / down
//   LD         in  1      load ld_val, saturated into [MIN_POS, MAX_POS]
//   ld_val     in  WIDTH  load value
//   mode       in  2      0 clamp, 1 wrap, 2 bounce, 3 clamp
//   pos        out WIDTH  registered position
//   at_max     out 1      pos == MAX_POS
//   at_min     out 1      pos == MIN_POS
//   dir        out 1      1 upward, 0 downward (last/current travel)
//   running    out 1      bounce FSM is in a RUN state
//   hit        out 1      one-cycle pulse: previous move hit a limit or wrapped
// Priority per edge: reset > LD > frame_tick move > hold.
// ---------------------------------------------------------------------------
module line_pos_tracker
  import line_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MIN_POS   = DEF_MIN_POS,
  parameter int MAX_POS   = DEF_MAX_POS,
  parameter int STEP      = 1,
  parameter int RESET_POS = DEF_MIN_POS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             UP,
  input  logic             DW,
  input  logic             LD,
  input  logic [WIDTH-1:0] ld_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] pos,
  output logic             at_max,
  output logic             at_min,
  output logic             dir,
  output logic             running,
  output logic             hit
);

  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_POS);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_POS);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_POS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             hit_q, hit_d;

  logic             mv_up, mv_dw, both;
  logic             bounce_mode;
  logic             req_up, req_dw;
  logic [WIDTH-1:0] step_pos;
  logic             step_flag;
  logic [WIDTH-1:0] ld_sat;

  assign mv_up       = UP & ~DW;
  assign mv_dw       = DW & ~UP;
  assign both        = UP & DW;
  assign bounce_mode = (mode == MODE_BOUNCE);

  // The stepper's direction comes straight from inputs/state so it does not
  // depend on the next-state logic that consumes its result.
  assign req_up = bounce_mode ? (state_q == ST_RUN_UP) : mv_up;
  assign req_dw = bounce_mode ? (state_q == ST_RUN_DW) : mv_dw;

  line_pos_step #(
    .WIDTH   (WIDTH),
    .MIN_POS (MIN_POS),
    .MAX_POS (MAX_POS),
    .STEP    (STEP)
  ) u_step (
    .pos        (pos_q),
    .up         (req_up),
    .dw         (req_dw),
    .wrap_en    (mode == MODE_WRAP),
    .next_pos   (step_pos),
    .limit_flag (step_flag)
  );

  assign ld_sat = (ld_val < MIN_W) ? MIN_W :
                  (ld_val > MAX_W) ? MAX_W : ld_val;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    hit_d   = 1'b0;
    if (LD) begin
      pos_d   = ld_sat;
      state_d = ST_HOLD;
    end else if (bounce_mode) begin
      unique case (state_q)
        ST_HOLD: begin
          // Start is sampled on any cycle; the first move waits for a tick.
          if (mv_up) begin
            state_d = ST_RUN_UP;
            dir_d   = 1'b1;
          end else if (mv_dw) begin
            state_d = ST_RUN_DW;
            dir_d   = 1'b0;
          end
        end
        ST_RUN_UP: begin
          if (both) begin
            state_d = ST_HOLD;
          end else if (frame_tick) begin
            pos_d = step_pos;
            if (step_flag) begin
              state_d = ST_RUN_DW;
              dir_d   = 1'b0;
              hit_d   = 1'b1;
            end
          end
        end
        ST_RUN_DW: begin
          if (both) begin
            state_d = ST_HOLD;
          end else if (frame_tick) begin
            pos_d = step_pos;
            if (step_flag) begin
              state_d = ST_RUN_UP;
              dir_d   = 1'b1;
              hit_d   = 1'b1;
            end
          end
        end
        default: state_d = ST_HOLD;
      endcase
    end else begin
      state_d = ST_HOLD;
      if (frame_tick && (mv_up || mv_dw)) begin
        pos_d = step_pos;
        dir_d = mv_up;
        hit_d = step_flag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_HOLD;
      pos_q   <= RESET_W;
      dir_q   <= 1'b1;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      hit_q   <= hit_d;
    end
  end

  assign pos     = pos_q;
  assign at_max  = (pos_q == MAX_W);
  assign at_min  = (pos_q == MIN_W);
  assign dir     = dir_q;
  assign running = (state_q != ST_HOLD);
  assign hit     = hit_q;

endmodule

// File: doc/line_pos_tracker.md
Name: line_pos_tracker

Overview:
- Parametrised position register for one on-screen line of the Wild Cube VGA game. Generalises the fixed 16-bit up/down/load line counter.
- Adds configurable width, bounds and step size, a per-frame move enable, and three motion modes: clamp, wrap, and autonomous bounce.
- Sits between the button/switch debouncers and the VGA pixel comparators. pos feeds the line-draw compare logic.

Parameters:
- WIDTH, 16, position width in bits.
- MIN_POS, 18, lowest legal position (inclusive).
- MAX_POS, 487, highest legal position (inclusive).
- STEP, 1, distance moved per frame tick. Legal range: 1 <= STEP <= MAX_POS-MIN_POS.
- RESET_POS, 18, position after reset. Must lie in [MIN_POS, MAX_POS].

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle strobe per video frame; movement happens only on this cycle
- UP  in  1  move/start toward MAX_POS
- DW  in  1  move/start toward MIN_POS
- LD  in  1  load ld_val
- ld_val  in  WIDTH  load value (from sw)
- mode  in  2  0=CLAMP, 1=WRAP, 2=BOUNCE, 3=treated as CLAMP
- pos  out  WIDTH  current position, registered
- at_max  out  1  pos==MAX_POS, combinational from pos
- at_min  out  1  pos==MIN_POS, combinational from pos
- dir  out  1  1=upward, 0=downward; last/current travel direction
- running  out  1  FSM in RUN_UP or RUN_DW
- hit  out  1  registered one-cycle pulse: the previous move reached a limit or wrapped

Behaviour:
- Priority per clock edge: reset > LD > frame_tick move > hold.
- Reset: pos=RESET_POS, state=HOLD, dir=1, hit=0. Reset wins over simultaneous LD/tick.
- LD: pos=ld_val saturated into [MIN_POS, MAX_POS], state=HOLD, hit=0, dir unchanged. Takes effect in any mode and state, including mid-run.
- Arithmetic: next-position sums computed at WIDTH+1 bits; no silent modular overflow.
- hit defaults to 0 every cycle. It is set only on a tick move as defined below and is never set on a non-tick cycle.
- CLAMP (manual):
  - On tick, UP&~DW: pos=min(pos+STEP, MAX_POS), dir=1.
  - On tick, DW&~UP: pos=max(pos-STEP, MIN_POS), dir=0.
  - Both or neither asserted: hold.
  - hit=1 if the resulting pos equals the limit in the direction of travel; this includes pushing while already at the limit.
- WRAP (manual): same move conditions as CLAMP, with R=MAX_POS-MIN_POS+1.
  - If pos+STEP>MAX_POS then pos=pos+STEP-R.
  - If pos-STEP<MIN_POS then pos=pos-STEP+R.
  - hit=1 only when a wrap occurred.
- BOUNCE: FSM with states HOLD, RUN_UP, RUN_DW.
  - HOLD: UP&~DW -> RUN_UP, dir=1. DW&~UP -> RUN_DW, dir=0. The start is sampled on any cycle; no tick is required.
  - RUN_UP, on tick: pos=min(pos+STEP, MAX_POS). If the result equals MAX_POS: state=RUN_DW, dir=0, hit=1.
  - RUN_DW: symmetric toward MIN_POS.
  - UP&DW together in either RUN state: go to HOLD with no move that cycle.
  - A single UP or DW in a RUN state: ignored.
- Leaving BOUNCE mode (mode!=2) forces state=HOLD on the next edge. Manual modes keep the FSM in HOLD; running=0.
- Mode changes take effect on the same edge; there is no pipeline. Movement latency is 1 cycle from the tick to the new pos.

Decomposition:
- Package line_pkg:
  - mode encodings: MODE_CLAMP, MODE_WRAP, MODE_BOUNCE
  - FSM state enum: ST_HOLD, ST_RUN_UP, ST_RUN_DW
  - default bound constants: 18 and 487
- Sub-module line_pos_step: purely combinational. Takes (pos, up/down request, mode, STEP, bounds) and returns next_pos and limit_flag. The top level holds the FSM, the LD saturation and the registers.

Test Plan:
- Reset, then idle 10 cycles with ticks -> pos=18, at_min=1, at_max=0, hit=0, running=0. Assert reset during a RUN_UP tick -> pos=18, HOLD.
- CLAMP, STEP=4: LD 485, then UP+tick -> pos=487, hit pulses 1 cycle. Second UP+tick -> pos=487, hit again. UP&DW+tick -> unchanged, hit=0.
- WRAP, STEP=4: LD 486, UP+tick -> pos=20, hit=1. LD 19, DW+tick -> pos=485, hit=1. LD 100, UP+tick -> 104, hit=0.
- BOUNCE, STEP=1: LD 485, pulse UP. Ticks give 486, 487 (hit, dir->0, RUN_DW), then 486, 485. UP&DW -> HOLD with pos frozen. Change mode to 0 while running -> HOLD.
- LD saturation: ld_val=600 -> 487. ld_val=3 -> 18. LD asserted together with a tick in RUN_UP -> load wins, state HOLD, hit=0.
- UP held with no frame_tick for 50 cycles in CLAMP -> pos unchanged. Only tick cycles move it.
